// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: host-side initiator for the 4-bit TT ALU tile.
// Takes one {a,b,op} command at a time, drives the ALU pins, waits out the
// ALU's registered latency, captures result and flags, and returns them on a
// response channel. ENC (op 8) results are decrypted with the shared key and
// checked against the launched operands.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. cmd_ready and rsp_valid are registered; the payload on either
// channel must be held stable by its source while valid=1 and ready=0.
module alu_cmd_driver #(
   parameter int unsigned ALU_LATENCY = 1,
   parameter logic [7:0]  ENC_KEY     = 8'hAB
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic [3:0] cmd_op,
   output logic [7:0] alu_ui,
   output logic [7:0] alu_uio,
   input  logic [7:0] alu_uo,
   input  logic [1:0] alu_flags,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_result,
   output logic       rsp_carry,
   output logic       rsp_ovf,
   output logic [3:0] rsp_op,
   output logic [3:0] rsp_tag,
   output logic [7:0] rsp_plain,
   output logic       rsp_enc_ok,
   output logic       rsp_illegal,
   output logic [1:0] dbg_state
);

   localparam logic [2:0] LAT_LOAD = 3'(ALU_LATENCY);
   localparam logic [3:0] OP_ENC   = 4'h8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t     state;
   logic [2:0] wait_cnt;
   logic [3:0] tag_cnt;

   // Decode of the launched command, evaluated against the live ALU output
   logic [3:0] launched_op;
   logic       is_enc;
   logic [7:0] plain_now;

   assign launched_op = alu_uio[3:0];
   assign is_enc      = (launched_op == OP_ENC);
   assign plain_now   = is_enc ? (alu_uo ^ ENC_KEY) : 8'h00;
   assign dbg_state   = state;

   // Command FSM: launch, wait out ALU latency, capture, hold until accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         alu_ui      <= 8'h00;
         alu_uio     <= 8'h00;
         wait_cnt    <= 3'd0;
         tag_cnt     <= 4'd0;
         rsp_result  <= 8'h00;
         rsp_carry   <= 1'b0;
         rsp_ovf     <= 1'b0;
         rsp_op      <= 4'h0;
         rsp_tag     <= 4'h0;
         rsp_plain   <= 8'h00;
         rsp_enc_ok  <= 1'b0;
         rsp_illegal <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  alu_ui    <= {cmd_a, cmd_b};
                  alu_uio   <= {4'b0000, cmd_op};
                  wait_cnt  <= LAT_LOAD;
                  cmd_ready <= 1'b0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt != 3'd0) begin
                  wait_cnt <= wait_cnt - 3'd1;
               end else begin
                  rsp_result  <= alu_uo;
                  rsp_carry   <= alu_flags[0];
                  rsp_ovf     <= alu_flags[1];
                  rsp_op      <= launched_op;
                  rsp_tag     <= tag_cnt;
                  rsp_plain   <= plain_now;
                  rsp_enc_ok  <= is_enc && (plain_now == alu_ui);
                  rsp_illegal <= (launched_op > OP_ENC);
                  tag_cnt     <= tag_cnt + 4'd1;
                  rsp_valid   <= 1'b1;
                  state       <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
